mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Datapath-to-memory access FSM: request seen in IDLE, mem_req from next cycle, DONE one cycle after mem_ack; stall holds the pipeline meanwhile.
// Optional BUSY watchdog under `define MEM_ACCESS_TIMEOUT_EN (expiry without ack -> sticky ERR).
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [3:0]  xferSize,
  input  logic [63:0] address,
  input  logic [63:0] wrData,
  output logic        stall,
  output logic [63:0] rdData,
  output logic        rdValid,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_size,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic [3:0]  size_q, size_d;
  logic        we_q, we_d;

  logic size_dw, size_byte, req_legal, req_any;

  assign req_any   = memRead | memWrite;
  assign size_dw   = (xferSize == 4'b1000);
  assign size_byte = (xferSize == 4'b0001);
  // Byte accesses may sit at any address; doublewords must be 8-byte aligned.
  assign req_legal = size_byte | (size_dw & (address[2:0] == 3'b000));

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_hit;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    we_d    = we_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    rdValid = 1'b0;
    err     = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (req_any) begin
          stall = 1'b1;
          if (req_legal) begin
            addr_d  = address;
            wdata_d = wrData;
            size_d  = xferSize;
            we_d    = memWrite;
            state_d = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        // An ack landing on the expiry cycle still completes the access.
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = (size_q == 4'b0001) ? {56'd0, mem_rdata[7:0]} : mem_rdata;
          end
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DONE: begin
        rdValid = ~we_q;
        state_d = IDLE;
      end
      ERR: begin
        stall = 1'b1;
        err   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;
  assign rdData    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle vector table plus hand-written error, reset and timeout sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [3:0]  xferSize;
  logic [63:0] address, wrData;
  logic        stall, rdValid, err;
  logic [63:0] rdData;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [3:0]  mem_size;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .memRead(memRead), .memWrite(memWrite), .xferSize(xferSize),
    .address(address), .wrData(wrData),
    .stall(stall), .rdData(rdData), .rdValid(rdValid), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [3:0]  sz;
    logic [63:0] addr, wdat;
    logic        ack;
    logic [63:0] mrd;
    logic        e_stall, e_req, e_we;
    logic [63:0] e_addr;
    logic [3:0]  e_size;
    logic [63:0] e_wdata;
    logic        e_rdv;
    logic [63:0] e_rdd;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0]  S8 = 4'b1000;
  localparam logic [3:0]  S1 = 4'b0001;
  localparam logic [63:0] R1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] R2 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] RB = 64'hFFFF_FFFF_FFFF_FF80;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [3:0] sz,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic ack, input logic [63:0] mrd);
    memRead = rd; memWrite = wr; xferSize = sz; address = a; wrData = wd;
    mem_ack = ack; mem_rdata = mrd;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // rd wr sz addr wdat ack mrd | stall req we addr size wdata rdv rdd err
    // LDUR 0x10, ack on first BUSY cycle
    vecs.push_back('{1,0,S8,64'h10,0,0,0,      1,0,0,64'h0, 4'h0,64'h0, 0,64'h0,0});
    vecs.push_back('{0,0,S8,0,0,1,R1,           1,1,0,64'h10,S8,64'h0, 0,64'h0,0});
    vecs.push_back('{0,0,0,0,0,0,0,             0,0,0,64'h10,S8,64'h0, 1,R1,0});
    vecs.push_back('{0,0,0,0,0,0,0,             0,0,0,64'h10,S8,64'h0, 0,R1,0});
    // STURB 0x3, ack on third BUSY cycle, stray acks after completion
    vecs.push_back('{0,1,S1,64'h3,64'hAB,0,0,   1,0,0,64'h10,S8,64'h0, 0,R1,0});
    vecs.push_back('{0,0,0,0,0,0,0,             1,1,1,64'h3, S1,64'hAB,0,R1,0});
    vecs.push_back('{0,0,0,0,0,0,0,             1,1,1,64'h3, S1,64'hAB,0,R1,0});
    vecs.push_back('{0,0,0,0,0,1,64'hDEAD,      1,1,1,64'h3, S1,64'hAB,0,R1,0});
    vecs.push_back('{0,0,0,0,0,1,64'hBEEF,      0,0,0,64'h3, S1,64'hAB,0,R1,0});
    vecs.push_back('{0,0,0,0,0,1,64'hBEEF,      0,0,0,64'h3, S1,64'hAB,0,R1,0});
    // LDURB 0x5 zero-extends; request during DONE is ignored
    vecs.push_back('{1,0,S1,64'h5,0,0,0,        1,0,0,64'h3, S1,64'hAB,0,R1,0});
    vecs.push_back('{0,0,0,0,0,1,RB,            1,1,0,64'h5, S1,64'h0, 0,R1,0});
    vecs.push_back('{1,0,S8,64'h18,0,0,0,       0,0,0,64'h5, S1,64'h0, 1,64'h80,0});
    vecs.push_back('{0,0,0,0,0,0,0,             0,0,0,64'h5, S1,64'h0, 0,64'h80,0});
    // read and write together: write wins
    vecs.push_back('{1,1,S8,64'h20,64'h55,0,0,  1,0,0,64'h5, S1,64'h0, 0,64'h80,0});
    vecs.push_back('{0,0,0,0,0,1,R1,            1,1,1,64'h20,S8,64'h55,0,64'h80,0});
    vecs.push_back('{0,0,0,0,0,0,0,             0,0,0,64'h20,S8,64'h55,0,64'h80,0});
    // LDUR 0x28, ack on second BUSY cycle
    vecs.push_back('{1,0,S8,64'h28,0,0,0,       1,0,0,64'h20,S8,64'h55,0,64'h80,0});
    vecs.push_back('{0,0,0,0,0,0,0,             1,1,0,64'h28,S8,64'h0, 0,64'h80,0});
    vecs.push_back('{0,0,0,0,0,1,R2,            1,1,0,64'h28,S8,64'h0, 0,64'h80,0});
    vecs.push_back('{0,0,0,0,0,0,0,             0,0,0,64'h28,S8,64'h0, 1,R2,0});

    idle_in();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #4;
    chk("rst stall", stall, 0);
    chk("rst req", mem_req, 0);
    chk("rst we", mem_we, 0);
    chk("rst rdv", rdValid, 0);
    chk("rst err", err, 0);
    chk("rst rddata", rdData, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst size", mem_size, 0);
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdat,
            vecs[i].ack, vecs[i].mrd);
      #4;
      chk($sformatf("v%0d stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d req", i), mem_req, vecs[i].e_req);
      chk($sformatf("v%0d we", i), mem_we, vecs[i].e_we);
      chk($sformatf("v%0d addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d size", i), mem_size, vecs[i].e_size);
      chk($sformatf("v%0d wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d rdv", i), rdValid, vecs[i].e_rdv);
      chk($sformatf("v%0d rddata", i), rdData, vecs[i].e_rdd);
      chk($sformatf("v%0d err", i), err, vecs[i].e_err);
      step();
    end

    // Reset during the second BUSY cycle abandons the access
    idle_in();
    drive(1'b1, 1'b0, S8, 64'h8, 64'd0, 1'b0, 64'd0);
    step();
    idle_in();
    #4 chk("rb busy1 req", mem_req, 1);
    step();
    reset = 1'b1;
    #4 chk("rb busy2 req", mem_req, 1);
    step();
    reset = 1'b0;
    #4;
    chk("rb post req", mem_req, 0);
    chk("rb post stall", stall, 0);
    chk("rb post rddata", rdData, 0);
    step();
    drive(1'b1, 1'b0, S8, 64'h30, 64'd0, 1'b0, 64'd0);
    step();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF);
    #4 chk("rb new addr", mem_addr, 64'h30);
    step();
    idle_in();
    #4;
    chk("rb new rdv", rdValid, 1);
    chk("rb new rddata", rdData, 64'h0123_4567_89AB_CDEF);
    step();

    // Misaligned doubleword load -> sticky ERR, no memory request
    drive(1'b1, 1'b0, S8, 64'h4, 64'd0, 1'b0, 64'd0);
    #4;
    chk("mis stall", stall, 1);
    chk("mis req", mem_req, 0);
    step();
    drive(1'b1, 1'b0, S8, 64'h10, 64'd0, 1'b1, R1);
    for (int k = 0; k < 5; k++) begin
      #4;
      chk($sformatf("mis err c%0d", k), err, 1);
      chk($sformatf("mis stall c%0d", k), stall, 1);
      chk($sformatf("mis req c%0d", k), mem_req, 0);
      step();
    end
    do_reset();
    #4;
    chk("mis clr err", err, 0);
    chk("mis clr stall", stall, 0);
    step();

    // Illegal transfer size
    drive(1'b0, 1'b1, 4'b0010, 64'h0, 64'h1, 1'b0, 64'd0);
    step();
    idle_in();
    #4;
    chk("badsz err", err, 1);
    chk("badsz req", mem_req, 0);
    step();
    do_reset();
    step();

`ifdef MEM_ACCESS_TIMEOUT_EN
    drive(1'b1, 1'b0, S8, 64'h40, 64'd0, 1'b0, 64'd0);
    step();
    idle_in();
    for (int k = 1; k <= 4; k++) begin
      #4 chk($sformatf("to busy%0d req", k), mem_req, 1);
      step();
    end
    #4;
    chk("to err", err, 1);
    chk("to req", mem_req, 0);
    step();
    do_reset();
    step();
    drive(1'b1, 1'b0, S8, 64'h48, 64'd0, 1'b0, 64'd0);
    step();
    idle_in();
    for (int k = 1; k <= 3; k++) step();
    drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b1, R2);
    #4 chk("to race req", mem_req, 1);
    step();
    idle_in();
    #4;
    chk("to race rdv", rdValid, 1);
    chk("to race err", err, 0);
    chk("to race rddata", rdData, R2);
    step();
`else
    drive(1'b1, 1'b0, S8, 64'h40, 64'd0, 1'b0, 64'd0);
    step();
    idle_in();
    for (int k = 1; k < 100; k++) step();
    #4;
    chk("nto c100 req", mem_req, 1);
    chk("nto c100 stall", stall, 1);
    chk("nto c100 err", err, 0);
    mem_ack = 1'b1;
    mem_rdata = R2;
    step();
    idle_in();
    #4;
    chk("nto done rdv", rdValid, 1);
    chk("nto done rddata", rdData, R2);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
